iter_div_eu: RTL and testbench

- Iterative radix-2 integer divide execution unit; the responder on the EU side of the generic reservation-station handshake.
- Accepts one operation (ctl, rs1, rs2, RS entry index) from the divider reservation station.
- Computes RV64M DIV/DIVU/REM/REMU and the W variants, then returns result, entry index and exception flags to the station.
- Single operation in flight; not pipelined.

---
 rtl/iter_div_eu.sv | 200 ++++++++++++++++++++
 tb/tb_iter_div_eu.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div_eu.sv
// Iterative radix-2 restoring divider EU for RV64M DIV/REM and W variants.
// Optional macro ITER_DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module iter_div_eu #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned EU_CTL_LEN = 4,
  parameter int unsigned EXCEPT_LEN = 2,
  parameter int unsigned RS_IDX_LEN = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [EU_CTL_LEN-1:0] ctl_i,
  input  logic [XLEN-1:0]       rs1_i,
  input  logic [XLEN-1:0]       rs2_i,
  input  logic [RS_IDX_LEN-1:0] entry_idx_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [RS_IDX_LEN-1:0] entry_idx_o,
  output logic [XLEN-1:0]       result_o,
  output logic                  except_raised_o,
  output logic [EXCEPT_LEN-1:0] except_code_o
);

  localparam int unsigned WLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMin = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] WMin = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*XLEN-1:0]     r_acc;      // {partial remainder, dividend/quotient}
  logic [XLEN-1:0]       r_divisor;
  logic                  r_is_rem;
  logic                  r_is_w;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [RS_IDX_LEN-1:0] r_idx;
  logic                  r_exc;
  logic [EXCEPT_LEN-1:0] r_code;
  logic                  r_issue_ready;
  logic                  r_result_valid;

  // Operation decode on the issue inputs
  logic            w_legal, w_is_w, w_is_rem, w_signed;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs;
  logic            w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [2*XLEN-1:0] w_acc_init;

  always_comb begin
    w_legal  = (ctl_i[EU_CTL_LEN-1:3] == '0);
    w_is_w   = ctl_i[2];
    w_is_rem = ctl_i[1];
    w_signed = ~ctl_i[0];
    if (w_is_w) begin
      w_a_ext = {{(XLEN-WLEN){w_signed & rs1_i[WLEN-1]}}, rs1_i[WLEN-1:0]};
      w_b_ext = {{(XLEN-WLEN){w_signed & rs2_i[WLEN-1]}}, rs2_i[WLEN-1:0]};
    end else begin
      w_a_ext = rs1_i;
      w_b_ext = rs2_i;
    end
    w_a_neg = w_signed & w_a_ext[XLEN-1];
    w_b_neg = w_signed & w_b_ext[XLEN-1];
    w_a_abs = w_a_neg ? (~w_a_ext + 1'b1) : w_a_ext;
    w_b_abs = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;
    w_div0  = (w_b_ext == '0);
    w_ovf   = w_signed & (w_b_ext == '1) & (w_a_ext == (w_is_w ? WMin : XMin));
    // W ops run 32 steps, so the dividend starts in the top 32 bits of the low half
    if (w_is_w) begin
      w_acc_init = {{XLEN{1'b0}}, w_a_abs[WLEN-1:0], {(XLEN-WLEN){1'b0}}};
    end else begin
      w_acc_init = {{XLEN{1'b0}}, w_a_abs};
    end
  end

  // One restoring step: shift left, trial-subtract, set quotient bit
  logic [XLEN:0]     w_hi;
  logic [XLEN-1:0]   w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_acc_step;

  always_comb begin
    w_hi       = r_acc[2*XLEN-1:XLEN-1];
    w_ge       = (w_hi >= {1'b0, r_divisor});
    w_diff     = w_hi[XLEN-1:0] - r_divisor;
    w_acc_step = {(w_ge ? w_diff : w_hi[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
  end

  // Result select, sign correction and W sign-extension
  logic [XLEN-1:0] w_mag, w_fix, w_res;
  logic            w_neg;

  always_comb begin
    w_mag = r_is_rem ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    w_neg = r_is_rem ? r_neg_r : r_neg_q;
    w_fix = w_neg ? (~w_mag + 1'b1) : w_mag;
    if (r_is_w) begin
      w_res = {{(XLEN-WLEN){w_fix[WLEN-1]}}, w_fix[WLEN-1:0]};
    end else begin
      w_res = w_fix;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_acc          <= '0;
      r_divisor      <= '0;
      r_is_rem       <= 1'b0;
      r_is_w         <= 1'b0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_idx          <= '0;
      r_exc          <= 1'b0;
      r_code         <= '0;
      r_issue_ready  <= 1'b1;
      r_result_valid <= 1'b0;
    end else if (flush_i) begin
      r_state        <= StIdle;
      r_issue_ready  <= 1'b1;
      r_result_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (issue_valid_i) begin
            r_is_rem      <= w_is_rem;
            r_is_w        <= w_is_w;
            r_idx         <= entry_idx_i;
            r_divisor     <= w_b_abs;
            r_exc         <= 1'b0;
            r_code        <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_issue_ready <= 1'b0;
            if (!w_legal) begin
              r_acc          <= '0;
              r_exc          <= 1'b1;
              r_code         <= EXCEPT_LEN'(2);
              r_state        <= StDone;
              r_result_valid <= 1'b1;
            end else if (w_div0) begin
              r_acc          <= {w_a_ext, {XLEN{1'b1}}};
              r_state        <= StDone;
              r_result_valid <= 1'b1;
            end else if (w_ovf) begin
              r_acc          <= {{XLEN{1'b0}}, w_a_ext};
              r_state        <= StDone;
              r_result_valid <= 1'b1;
`ifdef ITER_DIV_EARLY_OUT_EN
            end else if (w_a_abs < w_b_abs) begin
              r_acc          <= {w_a_ext, {XLEN{1'b0}}};
              r_state        <= StDone;
              r_result_valid <= 1'b1;
`endif
            end else begin
              r_acc   <= w_acc_init;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= w_is_w ? CNT_W'(WLEN-1) : CNT_W'(XLEN-1);
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          r_acc <= w_acc_step;
          if (r_cnt == '0) begin
            r_state        <= StDone;
            r_result_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StDone: begin
          if (result_ready_i) begin
            r_state        <= StIdle;
            r_result_valid <= 1'b0;
            r_issue_ready  <= 1'b1;
          end
        end
        default: begin
          r_state        <= StIdle;
          r_issue_ready  <= 1'b1;
          r_result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign issue_ready_o   = r_issue_ready;
  assign result_valid_o  = r_result_valid;
  assign entry_idx_o     = r_result_valid ? r_idx : '0;
  assign result_o        = r_result_valid ? w_res : '0;
  assign except_raised_o = r_result_valid & r_exc;
  assign except_code_o   = r_result_valid ? r_code : '0;

endmodule

// File: tb/tb_iter_div_eu.sv
// Scoreboard bench for iter_div_eu: directed RV64M cases, random ops checked
// against a behavioural model, backpressure, flush and async reset.
module tb_iter_div_eu;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [3:0]  ctl_i;
  logic [63:0] rs1_i;
  logic [63:0] rs2_i;
  logic [2:0]  entry_idx_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [2:0]  entry_idx_o;
  logic [63:0] result_o;
  logic        except_raised_o;
  logic [1:0]  except_code_o;

  iter_div_eu dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .flush_i        (flush_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .ctl_i          (ctl_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .entry_idx_i    (entry_idx_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .entry_idx_o    (entry_idx_o),
    .result_o       (result_o),
    .except_raised_o(except_raised_o),
    .except_code_o  (except_code_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef ITER_DIV_EARLY_OUT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] res;
    logic [2:0]  idx;
    logic        exc;
    logic [1:0]  code;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Behavioural reference: result and expected latency in cycles
  function automatic void ref_op(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] res, output int lat);
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb, sr;
    logic [31:0]        r32, ua32, ub32;
    logic [63:0]        ua, ub;
    bit w, rem, uns;
    w = ctl[2]; rem = ctl[1]; uns = ctl[0];
    res = '0; lat = 1;
    if (ctl[3]) return;
    if (!w) begin
      sa = a; sb = b;
      if (b == 64'd0) begin
        res = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        res = rem ? 64'd0 : a;
      end else begin
        if (uns) begin
          if (rem) res = a % b;
          else     res = a / b;
        end else begin
          if (rem) res = sa % sb;
          else     res = sa / sb;
        end
        ua  = (!uns && a[63]) ? -a : a;
        ub  = (!uns && b[63]) ? -b : b;
        lat = (Early && ua < ub) ? 1 : 65;
      end
    end else begin
      wa = a[31:0]; wb = b[31:0];
      if (b[31:0] == 32'd0) begin
        r32 = rem ? a[31:0] : 32'hFFFF_FFFF;
      end else if (!uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        r32 = rem ? 32'd0 : a[31:0];
      end else begin
        if (uns) begin
          if (rem) r32 = a[31:0] % b[31:0];
          else     r32 = a[31:0] / b[31:0];
        end else begin
          if (rem) sr = wa % wb;
          else     sr = wa / wb;
          r32 = sr;
        end
        ua32 = (!uns && a[31]) ? -a[31:0] : a[31:0];
        ub32 = (!uns && b[31]) ? -b[31:0] : b[31:0];
        lat  = (Early && ua32 < ub32) ? 1 : 33;
      end
      res = {{32{r32[31]}}, r32};
    end
  endfunction

  task automatic send(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] idx, input logic [63:0] res, input int lat);
    exp_t e;
    int   n = 0;
    while (!issue_ready_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!issue_ready_o) check_eq("issue_ready_timeout", {63'd0, issue_ready_o}, 64'd1);
    ctl_i = ctl; rs1_i = a; rs2_i = b; entry_idx_i = idx;
    issue_valid_i = 1'b1;
    e.res = res; e.idx = idx; e.exc = ctl[3]; e.code = ctl[3] ? 2'd2 : 2'd0; e.lat = 8'(lat);
    sb_q.push_back(e);
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
  endtask

  // Called straight after send: waits for the result and compares it
  task automatic wait_pop(input string tag, output exp_t e);
    int n = 1;
    while (!result_valid_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
      e = '0;
      return;
    end
    e = sb_q.pop_front();
    check_eq({tag, "_latency"}, 64'(n), 64'(e.lat));
    check_eq({tag, "_result"}, result_o, e.res);
    check_eq({tag, "_idx"}, {61'd0, entry_idx_o}, {61'd0, e.idx});
    check_eq({tag, "_exc"}, {61'd0, except_raised_o, except_code_o}, {61'd0, e.exc, e.code});
  endtask

  task automatic handshake(input string tag, input exp_t e, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      check_eq({tag, "_hold_valid"}, {63'd0, result_valid_o}, 64'd1);
      check_eq({tag, "_hold_result"}, result_o, e.res);
      check_eq({tag, "_hold_idx"}, {61'd0, entry_idx_o}, {61'd0, e.idx});
      check_eq({tag, "_hold_ready"}, {63'd0, issue_ready_o}, 64'd0);
    end
    result_ready_i = 1'b1;
    #1;
    check_eq({tag, "_ready_in_done"}, {63'd0, issue_ready_o}, 64'd0);
    @(posedge clk_i); #1;
    result_ready_i = 1'b0;
    check_eq({tag, "_ready_after"}, {63'd0, issue_ready_o}, 64'd1);
    check_eq({tag, "_valid_after"}, {63'd0, result_valid_o}, 64'd0);
  endtask

  task automatic run_dir(input string tag, input logic [3:0] ctl, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] idx, input logic [63:0] res,
                         input int lat);
    exp_t e;
    send(ctl, a, b, idx, res, lat);
    wait_pop(tag, e);
    handshake(tag, e, 0);
  endtask

  task automatic run_rand(input string tag, input logic [3:0] ctl, input logic [63:0] a,
                          input logic [63:0] b, input logic [2:0] idx);
    logic [63:0] res;
    int          lat;
    ref_op(ctl, a, b, res, lat);
    run_dir(tag, ctl, a, b, idx, res, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t        e;
    int          cnt;
    logic [3:0]  rc;
    logic [63:0] ra, rb;

    rst_n_i = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; result_ready_i = 1'b0;
    ctl_i = '0; rs1_i = '0; rs2_i = '0; entry_idx_i = '0;
    #12;
    check_eq("rst_issue_ready", {63'd0, issue_ready_o}, 64'd1);
    check_eq("rst_result_valid", {63'd0, result_valid_o}, 64'd0);
    check_eq("rst_result", result_o, 64'd0);
    check_eq("rst_exc", {61'd0, except_raised_o, except_code_o}, 64'd0);
    check_eq("rst_idx", {61'd0, entry_idx_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    run_dir("div_m7_2", 4'd0, -64'sd7, 64'd2, 3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_dir("rem_m7_2", 4'd2, -64'sd7, 64'd2, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_dir("divu_100_7", 4'd1, 64'd100, 64'd7, 3'd3, 64'd14, 65);
    run_dir("remu_100_7", 4'd3, 64'd100, 64'd7, 3'd4, 64'd2, 65);
    run_dir("divw_ovf", 4'd4, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd5,
            64'hFFFF_FFFF_8000_0000, 1);
    run_dir("div_by0", 4'd0, 64'd5, 64'd0, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_dir("rem_by0", 4'd2, 64'd5, 64'd0, 3'd7, 64'd5, 1);
    run_dir("div_ovf", 4'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0,
            64'h8000_0000_0000_0000, 1);
    run_dir("rem_ovf", 4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'd0, 1);
    run_dir("illegal9", 4'd9, 64'd77, 64'd3, 3'd2, 64'd0, 1);
    run_dir("divu_3_10", 4'd1, 64'd3, 64'd10, 3'd3, 64'd0, Early ? 1 : 65);
    run_dir("remw_m7_2", 4'd6, 64'h0000_0000_FFFF_FFF9, 64'd2, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_dir("divuw_max", 4'd5, 64'h1234_5678_FFFF_FFFF, 64'd1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Backpressure with result_ready_i low for five cycles
    send(4'd1, 64'd100, 64'd7, 3'd3, 64'd14, 65);
    wait_pop("bp", e);
    handshake("bp", e, 5);

    // Flush in the tenth CALC cycle
    send(4'd1, 64'hFFFF_0000_1234_5678, 64'd3, 3'd5, 64'd0, 65);
    repeat (9) begin
      @(posedge clk_i); #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    void'(sb_q.pop_back());
    check_eq("flush_issue_ready", {63'd0, issue_ready_o}, 64'd1);
    check_eq("flush_valid", {63'd0, result_valid_o}, 64'd0);
    cnt = 0;
    repeat (70) begin
      @(posedge clk_i); #1;
      if (result_valid_o) cnt++;
    end
    check_eq("flush_no_result", 64'(cnt), 64'd0);
    run_dir("divu_9_3", 4'd1, 64'd9, 64'd3, 3'd6, 64'd3, 65);

    // Issue coinciding with flush is dropped
    ctl_i = 4'd0; rs1_i = 64'd5; rs2_i = 64'd0; entry_idx_i = 3'd1;
    issue_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0; flush_i = 1'b0;
    check_eq("flush_drop_ready", {63'd0, issue_ready_o}, 64'd1);
    @(posedge clk_i); #1;
    check_eq("flush_drop_valid", {63'd0, result_valid_o}, 64'd0);

    // Asynchronous reset in the middle of CALC
    send(4'd0, 64'd1000, 64'd7, 3'd2, 64'd0, 65);
    repeat (5) begin
      @(posedge clk_i); #1;
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    void'(sb_q.pop_back());
    check_eq("arst_issue_ready", {63'd0, issue_ready_o}, 64'd1);
    check_eq("arst_valid", {63'd0, result_valid_o}, 64'd0);
    check_eq("arst_result", result_o, 64'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    run_dir("after_arst", 4'd0, 64'd1000, 64'd7, 3'd7, 64'd142, 65);

    // Random ops against the reference model
    for (int i = 0; i < 16; i++) begin
      rc = 4'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) rb = 64'($urandom_range(0, 20));
      else if ($urandom_range(0, 1) == 0) rb = {32'd0, $urandom};
      else rb = {$urandom, $urandom};
      run_rand($sformatf("rand%0d", i), rc, ra, rb, 3'(i));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
